// File: rtl/wavetable_bank_scheduler_pkg.sv
// Shared constants for the wavetable bank scheduler: geometry, FSM encoding
// and the bit layout of the status word.
package wavetable_bank_scheduler_pkg;

    localparam int NUM_VOICES = 3;
    localparam int NUM_BANKS  = 4;
    localparam int ADDRWIDTH  = 8;
    localparam int DATAWIDTH  = 16;
    localparam int BANKWIDTH  = 2;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    // status = {pending[2:0], forced_sticky[2:0], 4'b0, rbank[5:0]}
    localparam int STAT_RBANK_LSB  = 0;
    localparam int STAT_FORCED_LSB = 10;
    localparam int STAT_PEND_LSB   = 13;

endpackage

// File: rtl/wavetable_bank_scheduler_voice_swap_fsm.sv
// Per-voice bank-swap controller: holds the active read bank, the pending bank
// and the forced-swap watchdog. Swaps are applied on wrap or watchdog expiry.
module voice_swap_fsm
    import wavetable_bank_scheduler_pkg::*;
#(
    parameter int TIMEOUT_W = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 commit,
    input  logic [BANKWIDTH-1:0] commit_bank,
    input  logic                 wrap,
    output logic [BANKWIDTH-1:0] rbank,
    output logic                 pending,
    output logic [BANKWIDTH-1:0] pending_bank,
    output logic                 forced,
    output logic                 swap_done
);

    logic [0:0]           state;
    logic [TIMEOUT_W-1:0] wd;
    logic                 wd_sat;

    assign wd_sat  = &wd;
    assign pending = (state == ST_PENDING);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            rbank        <= '0;
            pending_bank <= '0;
            wd           <= '0;
            forced       <= 1'b0;
            swap_done    <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (commit) begin
                        if (commit_bank == rbank) begin
                            swap_done <= 1'b1;
                        end else begin
                            state        <= ST_PENDING;
                            pending_bank <= commit_bank;
                            wd           <= '0;
                        end
                    end
                end
                ST_PENDING: begin
                    if (wrap || wd_sat) begin
                        rbank     <= pending_bank;
                        swap_done <= 1'b1;
                        forced    <= !wrap;
                        // A commit landing on the swap cycle is judged against the new rbank.
                        if (commit && (commit_bank != pending_bank)) begin
                            pending_bank <= commit_bank;
                            wd           <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (commit) begin
                        if (commit_bank == rbank) begin
                            state     <= ST_IDLE;
                            swap_done <= 1'b1;
                        end else begin
                            pending_bank <= commit_bank;
                            wd           <= '0;
                        end
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wavetable_bank_scheduler.sv
// Routes host wavetable writes to non-playing banks and owns each voice's
// read-bank select, deferring bank swaps to the voice's waveform wrap.
module wavetable_bank_scheduler
    import wavetable_bank_scheduler_pkg::*;
#(
    parameter int TIMEOUT_W = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    input  logic [1:0]                wr_voice,
    input  logic [BANKWIDTH-1:0]      wr_bank,
    input  logic [ADDRWIDTH-1:0]      wr_addr,
    input  logic [DATAWIDTH-1:0]      wr_data,
    input  logic                      commit_valid,
    input  logic [1:0]                commit_voice,
    input  logic [BANKWIDTH-1:0]      commit_bank,
    input  logic [NUM_VOICES-1:0]     wrap,
    output logic [NUM_VOICES-1:0]     ram_we,
    output logic [BANKWIDTH-1:0]      ram_wbank,
    output logic [ADDRWIDTH-1:0]      ram_waddr,
    output logic [DATAWIDTH-1:0]      ram_wdata,
    output logic [2*NUM_VOICES-1:0]   rbank,
    output logic                      wr_err,
    output logic [NUM_VOICES-1:0]     swap_done,
    output logic [DATAWIDTH-1:0]      status
);

    logic [NUM_VOICES-1:0] pending;
    logic [NUM_VOICES-1:0] forced;
    logic [BANKWIDTH-1:0]  pending_bank [NUM_VOICES];

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_swap_fsm #(.TIMEOUT_W(TIMEOUT_W)) u_fsm (
            .clk          (clk),
            .rst          (rst),
            .commit       (commit_valid && (commit_voice == 2'(v))),
            .commit_bank  (commit_bank),
            .wrap         (wrap[v]),
            .rbank        (rbank[2*v +: 2]),
            .pending      (pending[v]),
            .pending_bank (pending_bank[v]),
            .forced       (forced[v]),
            .swap_done    (swap_done[v])
        );
    end

    // Legality uses the registered (pre-commit) voice state, so a write to a
    // bank committed in the same cycle still goes through.
    logic                  voice_ok;
    logic [BANKWIDTH-1:0]  sel_rbank;
    logic                  sel_pending;
    logic [BANKWIDTH-1:0]  sel_pbank;
    logic                  accept;
    logic [NUM_VOICES-1:0] we_onehot;

    always_comb begin
        voice_ok    = 1'b0;
        sel_rbank   = '0;
        sel_pending = 1'b0;
        sel_pbank   = '0;
        we_onehot   = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (wr_voice == 2'(v)) begin
                voice_ok     = 1'b1;
                sel_rbank    = rbank[2*v +: 2];
                sel_pending  = pending[v];
                sel_pbank    = pending_bank[v];
                we_onehot[v] = 1'b1;
            end
        end
    end

    assign accept = wr_valid && voice_ok && (wr_bank != sel_rbank) &&
                    !(sel_pending && (wr_bank == sel_pbank));

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_we    <= '0;
            ram_wbank <= '0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            wr_err    <= 1'b0;
        end else begin
            ram_we <= accept ? we_onehot : '0;
            wr_err <= wr_valid && !accept;
            if (accept) begin
                ram_wbank <= wr_bank;
                ram_waddr <= wr_addr;
                ram_wdata <= wr_data;
            end
        end
    end

    always_comb begin
        status = '0;
        status[STAT_RBANK_LSB  +: 2*NUM_VOICES] = rbank;
        status[STAT_FORCED_LSB +: NUM_VOICES]   = forced;
        status[STAT_PEND_LSB   +: NUM_VOICES]   = pending;
    end

endmodule

// File: tb/tb_wavetable_bank_scheduler.sv
// Directed vector bench for wavetable_bank_scheduler with a short watchdog.
module tb_wavetable_bank_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [1:0]  wr_voice;
    logic [1:0]  wr_bank;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        commit_valid;
    logic [1:0]  commit_voice;
    logic [1:0]  commit_bank;
    logic [2:0]  wrap;
    logic [2:0]  ram_we;
    logic [1:0]  ram_wbank;
    logic [7:0]  ram_waddr;
    logic [15:0] ram_wdata;
    logic [5:0]  rbank;
    logic        wr_err;
    logic [2:0]  swap_done;
    logic [15:0] status;

    int n_chk  = 0;
    int n_fail = 0;

    wavetable_bank_scheduler #(.TIMEOUT_W(4)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_voice(wr_voice), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .commit_valid(commit_valid), .commit_voice(commit_voice), .commit_bank(commit_bank),
        .wrap(wrap),
        .ram_we(ram_we), .ram_wbank(ram_wbank), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .rbank(rbank), .wr_err(wr_err), .swap_done(swap_done), .status(status)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wv;  logic [1:0] wvo; logic [1:0] wb; logic [7:0] wa; logic [15:0] wd;
        logic        cv;  logic [1:0] cvo; logic [1:0] cb;
        logic [2:0]  wrp;
        logic [2:0]  e_we; logic [1:0] e_wb; logic [7:0] e_wa; logic [15:0] e_wd;
        logic        e_err; logic [2:0] e_sd; logic [5:0] e_rb; logic [15:0] e_st;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic wv, logic [1:0] wvo, logic [1:0] wb, logic [7:0] wa,
                                logic [15:0] wd, logic cv, logic [1:0] cvo, logic [1:0] cb,
                                logic [2:0] wrp, logic [2:0] e_we, logic [1:0] e_wb,
                                logic [7:0] e_wa, logic [15:0] e_wd, logic e_err,
                                logic [2:0] e_sd, logic [5:0] e_rb, logic [15:0] e_st);
        vec_t r;
        r.wv = wv; r.wvo = wvo; r.wb = wb; r.wa = wa; r.wd = wd;
        r.cv = cv; r.cvo = cvo; r.cb = cb; r.wrp = wrp;
        r.e_we = e_we; r.e_wb = e_wb; r.e_wa = e_wa; r.e_wd = e_wd;
        r.e_err = e_err; r.e_sd = e_sd; r.e_rb = e_rb; r.e_st = e_st;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        wr_valid = 0; wr_voice = 0; wr_bank = 0; wr_addr = 0; wr_data = 0;
        commit_valid = 0; commit_voice = 0; commit_bank = 0; wrap = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        //                wv wvo wb  wa     wd        cv cvo cb  wrap    we    wb  wa     wd        err sd     rb     st
        vecs[0]  = mk(1, 1, 2, 8'h10, 16'hBEEF, 0, 0, 0, 3'b000, 3'b010, 2, 8'h10, 16'hBEEF, 0, 3'b000, 6'h00, 16'h0000);
        vecs[1]  = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 3'b000, 3'b000, 2, 8'h10, 16'hBEEF, 0, 3'b000, 6'h00, 16'h0000);
        vecs[2]  = mk(1, 0, 0, 8'h20, 16'h1111, 0, 0, 0, 3'b000, 3'b000, 2, 8'h10, 16'hBEEF, 1, 3'b000, 6'h00, 16'h0000);
        vecs[3]  = mk(1, 3, 1, 8'h21, 16'h1212, 0, 0, 0, 3'b000, 3'b000, 2, 8'h10, 16'hBEEF, 1, 3'b000, 6'h00, 16'h0000);
        vecs[4]  = mk(0, 0, 0, 8'h00, 16'h0000, 1, 2, 3, 3'b000, 3'b000, 2, 8'h10, 16'hBEEF, 0, 3'b000, 6'h00, 16'h8000);
        vecs[5]  = mk(1, 2, 3, 8'h30, 16'h2222, 0, 0, 0, 3'b000, 3'b000, 2, 8'h10, 16'hBEEF, 1, 3'b000, 6'h00, 16'h8000);
        vecs[6]  = mk(1, 2, 1, 8'h31, 16'h3333, 0, 0, 0, 3'b000, 3'b100, 1, 8'h31, 16'h3333, 0, 3'b000, 6'h00, 16'h8000);
        vecs[7]  = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 3'b100, 3'b000, 1, 8'h31, 16'h3333, 0, 3'b100, 6'h30, 16'h0030);
        vecs[8]  = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 3'b000, 3'b000, 1, 8'h31, 16'h3333, 0, 3'b000, 6'h30, 16'h0030);
        vecs[9]  = mk(0, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 3'b000, 3'b000, 1, 8'h31, 16'h3333, 0, 3'b001, 6'h30, 16'h0030);
        vecs[10] = mk(0, 0, 0, 8'h00, 16'h0000, 1, 3, 1, 3'b000, 3'b000, 1, 8'h31, 16'h3333, 0, 3'b000, 6'h30, 16'h0030);
        vecs[11] = mk(0, 0, 0, 8'h00, 16'h0000, 1, 0, 1, 3'b000, 3'b000, 1, 8'h31, 16'h3333, 0, 3'b000, 6'h30, 16'h2030);
        vecs[12] = mk(1, 0, 2, 8'h40, 16'h4444, 1, 0, 2, 3'b001, 3'b001, 2, 8'h40, 16'h4444, 0, 3'b001, 6'h31, 16'h2031);
        vecs[13] = mk(1, 0, 2, 8'h41, 16'h4545, 0, 0, 0, 3'b000, 3'b000, 2, 8'h40, 16'h4444, 1, 3'b000, 6'h31, 16'h2031);
        vecs[14] = mk(1, 0, 1, 8'h42, 16'h4646, 0, 0, 0, 3'b000, 3'b000, 2, 8'h40, 16'h4444, 1, 3'b000, 6'h31, 16'h2031);
        vecs[15] = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 3'b001, 3'b000, 2, 8'h40, 16'h4444, 0, 3'b001, 6'h32, 16'h0032);
        vecs[16] = mk(1, 1, 1, 8'h50, 16'h5555, 1, 1, 1, 3'b000, 3'b010, 1, 8'h50, 16'h5555, 0, 3'b000, 6'h32, 16'h4032);
        vecs[17] = mk(1, 1, 1, 8'h51, 16'h5656, 0, 0, 0, 3'b000, 3'b000, 1, 8'h50, 16'h5555, 1, 3'b000, 6'h32, 16'h4032);
        vecs[18] = mk(0, 0, 0, 8'h00, 16'h0000, 1, 1, 0, 3'b000, 3'b000, 1, 8'h50, 16'h5555, 0, 3'b010, 6'h32, 16'h0032);
        vecs[19] = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 3'b010, 3'b000, 1, 8'h50, 16'h5555, 0, 3'b000, 6'h32, 16'h0032);
        vecs[20] = mk(0, 0, 0, 8'h00, 16'h0000, 1, 1, 3, 3'b010, 3'b000, 1, 8'h50, 16'h5555, 0, 3'b000, 6'h32, 16'h4032);
        vecs[21] = mk(0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 3'b010, 3'b000, 1, 8'h50, 16'h5555, 0, 3'b010, 6'h3E, 16'h003E);

        idle_inputs();
        rst = 1'b1;
        step();
        step();
        chk("reset_ram_we", 32'(ram_we), 0);
        chk("reset_waddr", 32'(ram_waddr), 0);
        chk("reset_wdata", 32'(ram_wdata), 0);
        chk("reset_rbank", 32'(rbank), 0);
        chk("reset_status", 32'(status), 0);
        chk("reset_err_sd", 32'({wr_err, swap_done}), 0);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            wr_valid = vecs[i].wv; wr_voice = vecs[i].wvo; wr_bank = vecs[i].wb;
            wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            commit_valid = vecs[i].cv; commit_voice = vecs[i].cvo; commit_bank = vecs[i].cb;
            wrap = vecs[i].wrp;
            step();
            chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_wbank", i), 32'(ram_wbank), 32'(vecs[i].e_wb));
            chk($sformatf("v%0d_waddr", i), 32'(ram_waddr), 32'(vecs[i].e_wa));
            chk($sformatf("v%0d_wdata", i), 32'(ram_wdata), 32'(vecs[i].e_wd));
            chk($sformatf("v%0d_wr_err", i), 32'(wr_err), 32'(vecs[i].e_err));
            chk($sformatf("v%0d_swap_done", i), 32'(swap_done), 32'(vecs[i].e_sd));
            chk($sformatf("v%0d_rbank", i), 32'(rbank), 32'(vecs[i].e_rb));
            chk($sformatf("v%0d_status", i), 32'(status), 32'(vecs[i].e_st));
        end

        // Watchdog: voice1 commit to bank1, no wrap; saturation at 15 forces the swap.
        begin
            int n;
            commit_valid = 1; commit_voice = 1; commit_bank = 1;
            step();
            n = 0;
            for (int k = 1; k <= 40; k++) begin
                step();
                if (swap_done[1]) begin
                    n = k;
                    break;
                end
                chk("wd_rbank_hold", 32'(rbank), 32'h3E);
            end
            chk("wd_force_cycle", n, 16);
            chk("wd_rbank", 32'(rbank), 32'h36);
            chk("wd_status_forced", 32'(status), 32'h0836);
            step();
            chk("wd_sd_single", 32'(swap_done), 0);
        end

        // A normal wrap-swap clears the sticky forced flag.
        commit_valid = 1; commit_voice = 1; commit_bank = 2;
        step();
        chk("sticky_held_pending", 32'(status), 32'h4836);
        wrap = 3'b010;
        step();
        chk("sticky_clear_rbank", 32'(rbank), 32'h3A);
        chk("sticky_clear_status", 32'(status), 32'h003A);

        // Reset mid-operation: voice0 pending, write in flight on the reset cycle.
        commit_valid = 1; commit_voice = 0; commit_bank = 1;
        step();
        chk("pre_rst_pending", 32'(status[13]), 1);
        wr_valid = 1; wr_voice = 2; wr_bank = 0; wr_addr = 8'h77; wr_data = 16'h7777;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_rbank", 32'(rbank), 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_waddr", 32'(ram_waddr), 0);
        wr_valid = 1; wr_voice = 0; wr_bank = 0; wr_addr = 8'h01; wr_data = 16'h0001;
        step();
        chk("post_rst_reject_err", 32'(wr_err), 1);
        chk("post_rst_reject_we", 32'(ram_we), 0);
        step();
        chk("post_rst_err_pulse", 32'(wr_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
